// File: rtl/image_loader.sv
// Pixel-stream front end for dnn_top: fills a 784-entry Q8.8 frame buffer, launches
// one inference per frame, and captures the predicted digit when the network finishes.
module image_loader #(
  parameter int NPIX   = 784,
  parameter int PIX_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         s_pixel,
  input  logic                     s_valid,
  input  logic                     s_first,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] input_vector [NPIX],
  output logic                     dnn_start,
  input  logic                     dnn_done,
  input  logic [3:0]               dnn_digit,
  output logic [3:0]               result_digit,
  output logic                     result_valid,
  output logic [7:0]               resync_cnt,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NPIX);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             accept_s;

  // 0..255 maps onto 0..256 so that full scale lands exactly on 1.0 in Q8.8.
  function automatic logic [DATA_W-1:0] pix_to_q88(input logic [PIX_W-1:0] p);
    pix_to_q88 = DATA_W'(p) + DATA_W'(p[PIX_W-1]);
  endfunction

  assign accept_s = s_valid && s_ready;

  // Frame-fill / launch / wait sequencer, including the frame buffer and all outputs.
  always_ff @(posedge clk) begin
    dnn_start    <= 1'b0;
    result_valid <= 1'b0;
    if (rst) begin
      state_r      <= ST_FILL;
      idx_r        <= '0;
      s_ready      <= 1'b1;
      busy         <= 1'b0;
      result_digit <= 4'd0;
      resync_cnt   <= 8'd0;
      for (int i = 0; i < NPIX; i++) begin
        input_vector[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            if (s_first) begin
              // Restart: a mid-frame s_first discards the partial frame position.
              input_vector[0] <= pix_to_q88(s_pixel);
              idx_r           <= IDX_W'(1);
              if (idx_r != '0 && resync_cnt != 8'hFF) begin
                resync_cnt <= resync_cnt + 8'd1;
              end
            end else if (idx_r == '0) begin
              idx_r <= '0;
            end else if (idx_r == IDX_W'(NPIX - 1)) begin
              input_vector[idx_r] <= pix_to_q88(s_pixel);
              idx_r               <= '0;
              state_r             <= ST_LAUNCH;
              dnn_start           <= 1'b1;
              s_ready             <= 1'b0;
              busy                <= 1'b1;
            end else begin
              input_vector[idx_r] <= pix_to_q88(s_pixel);
              idx_r               <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_LAUNCH: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dnn_done) begin
            result_digit <= dnn_digit;
            result_valid <= 1'b1;
            state_r      <= ST_FILL;
            s_ready      <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_FILL;
          idx_r   <= '0;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader: reset, full frames with and without
// gaps, completion capture, resync handling, sync drop and reset while waiting.
module tb_image_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        s_pixel;
  logic              s_valid;
  logic              s_first;
  logic              s_ready;
  logic signed [15:0] iv [784];
  logic              dnn_start;
  logic              dnn_done;
  logic [3:0]        dnn_digit;
  logic [3:0]        result_digit;
  logic              result_valid;
  logic [7:0]        resync_cnt;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  image_loader dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_first(s_first),
    .s_ready(s_ready), .input_vector(iv), .dnn_start(dnn_start), .dnn_done(dnn_done),
    .dnn_digit(dnn_digit), .result_digit(result_digit), .result_valid(result_valid),
    .resync_cnt(resync_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dnn_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected Q8.8 value, written as a comparison rather than a bit pick.
  function automatic int q88(input int p);
    return (p >= 128) ? p + 1 : p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pix, input logic first);
    s_valid = 1'b1; s_pixel = pix[7:0]; s_first = first;
    tick();
    s_valid = 1'b0; s_first = 1'b0;
  endtask

  // n continuous accepts, pixel value (base+k) mod 256, no s_first.
  task automatic feed(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1; s_first = 1'b0; s_pixel = 8'((base + k) % 256);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_inference(input int digit, input string tag);
    repeat (40) tick();
    dnn_done = 1'b1; dnn_digit = digit[3:0];
    tick();
    dnn_done = 1'b0;
    check({tag, "_rvalid"}, result_valid, 1);
    check({tag, "_digit"}, result_digit, digit);
    check({tag, "_ready"}, s_ready, 1);
    check({tag, "_busy"}, busy, 0);
    tick();
    check({tag, "_rvalid_drop"}, result_valid, 0);
  endtask

  initial begin
    int c;
    int i;
    int sc;
    rst = 1'b1; s_pixel = 8'd0; s_valid = 1'b0; s_first = 1'b0;
    dnn_done = 1'b0; dnn_digit = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", s_ready, 1);
    check("rst_start", dnn_start, 0);
    check("rst_busy", busy, 0);
    check("rst_resync", resync_cnt, 0);
    check("rst_iv0", iv[0], 0);
    check("rst_iv783", iv[783], 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_digit", result_digit, 0);

    // Frame 1: continuous valid, pixel i = i mod 256.
    sc = start_cnt;
    push(0, 1'b1);
    feed(782, 1);
    check("f1_nostart_early", dnn_start, 0);
    check("f1_ready_early", s_ready, 1);
    feed(1, 783);
    check("f1_start", dnn_start, 1);
    check("f1_ready_launch", s_ready, 0);
    check("f1_busy_launch", busy, 1);
    check("f1_iv0", iv[0], 0);
    check("f1_iv127", iv[127], 127);
    check("f1_iv128", iv[128], 129);
    check("f1_iv255", iv[255], 256);
    check("f1_iv783", iv[783], 15);
    // Offer pixels while waiting; none may land.
    s_valid = 1'b1; s_first = 1'b1; s_pixel = 8'd99;
    tick();
    check("f1_start_gone", dnn_start, 0);
    check("f1_busy_wait", busy, 1);
    check("f1_ready_wait", s_ready, 0);
    repeat (4) tick();
    s_valid = 1'b0; s_first = 1'b0;
    check("f1_wait_iv0", iv[0], 0);
    check("f1_wait_iv1", iv[1], 1);
    check("f1_start_pulses", start_cnt - sc, 1);
    finish_inference(7, "f1");
    dnn_done = 1'b1; dnn_digit = 4'd2;
    tick();
    dnn_done = 1'b0;
    check("fill_done_ignored", result_valid, 0);
    check("fill_digit_kept", result_digit, 7);

    // Frame 2: valid pattern 1,0,0,1; pixel i = 255 - (i mod 256).
    i = 0; c = 0; sc = start_cnt;
    while (i < 784) begin
      s_valid = (c % 4 == 0) || (c % 4 == 3);
      s_first = s_valid && (i == 0);
      s_pixel = s_valid ? 8'(255 - (i % 256)) : 8'd77;
      tick();
      if (s_valid) i++;
      c++;
    end
    s_valid = 1'b0; s_first = 1'b0;
    check("f2_start", dnn_start, 1);
    check("f2_iv0", iv[0], q88(255));
    check("f2_iv127", iv[127], q88(128));
    check("f2_iv200", iv[200], q88(55));
    check("f2_iv783", iv[783], q88(240));
    tick();
    check("f2_start_pulses", start_cnt - sc, 1);
    finish_inference(3, "f2");

    // Frame 3: restart at pixel 300 with value 200.
    sc = start_cnt;
    push(0, 1'b1);
    feed(299, 1);
    push(200, 1'b1);
    check("rs_cnt", resync_cnt, 1);
    check("rs_iv0", iv[0], 201);
    feed(782, 1);
    check("rs_nostart", dnn_start, 0);
    check("rs_ready", s_ready, 1);
    feed(1, 783);
    check("rs_start", dnn_start, 1);
    check("rs_iv1", iv[1], 1);
    check("rs_iv783", iv[783], 15);
    tick();
    check("rs_start_pulses", start_cnt - sc, 1);
    finish_inference(5, "rs");

    // Sync drop: five pixels at idx 0 without s_first are discarded.
    for (int k = 0; k < 5; k++) push(50, 1'b0);
    check("drop_iv0", iv[0], 201);
    check("drop_iv4", iv[4], 4);
    check("drop_ready", s_ready, 1);
    push(10, 1'b1);
    check("drop_first_iv0", iv[0], 10);
    check("drop_resync_same", resync_cnt, 1);

    // s_first at the last index restarts instead of launching.
    feed(782, 1);
    push(60, 1'b1);
    check("last_first_nostart", dnn_start, 0);
    check("last_first_resync", resync_cnt, 2);
    check("last_first_iv0", iv[0], 60);
    check("last_first_busy", busy, 0);
    feed(783, 1);
    check("f5_start", dnn_start, 1);

    // Reset while waiting; a later done must be ignored.
    repeat (3) tick();
    check("f5_busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrst_ready", s_ready, 1);
    check("wrst_busy", busy, 0);
    check("wrst_start", dnn_start, 0);
    check("wrst_resync", resync_cnt, 0);
    check("wrst_iv0", iv[0], 0);
    check("wrst_digit", result_digit, 0);
    dnn_done = 1'b1; dnn_digit = 4'd9;
    tick();
    dnn_done = 1'b0;
    check("wrst_done_ignored", result_valid, 0);
    check("wrst_digit_kept", result_digit, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
